// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier, parametrised in exponent and fraction width.
// Round-to-nearest-even, flush-to-zero, canonical qNaN, stall-on-backpressure.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [3:0]   out_flags
);
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
  } cls_t;

  // Exponent 0 counts as zero whatever the fraction: subnormals are flushed.
  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    cls_t c;
    c.nan  = (&e) & (|f);
    c.snan = (&e) & (|f) & ~f[MAN_W-1];
    c.inf  = (&e) & ~(|f);
    c.zero = ~(|e);
    return c;
  endfunction

  logic              stall_s, en_s;
  logic              v0_r, v1_r, v2_r, out_valid_r;
  logic [W-1:0]      a0_r, b0_r, out_res_r;
  logic [3:0]        out_flags_r;

  assign stall_s   = out_valid_r & ~out_ready;
  assign en_s      = ~stall_s;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_res   = out_res_r;
  assign out_flags = out_flags_r;

  // Operand capture register; holds while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r <= 1'b0;
      a0_r <= '0;
      b0_r <= '0;
    end else if (en_s) begin
      v0_r <= in_valid;
      if (in_valid) begin
        a0_r <= in_a;
        b0_r <= in_b;
      end
    end
  end

  // S1: unpack, classify, multiply
  cls_t              cls_a_s, cls_b_s, cls_any_s;
  logic [MAN_W:0]    ma_s, mb_s;
  logic [PW-1:0]     prod_s;
  logic              sign1_r;
  cls_t              cls1_r;
  logic [EXP_W-1:0]  ea1_r, eb1_r;
  logic [PW-1:0]     prod1_r;

  assign cls_a_s   = classify(a0_r[W-2:MAN_W], a0_r[MAN_W-1:0]);
  assign cls_b_s   = classify(b0_r[W-2:MAN_W], b0_r[MAN_W-1:0]);
  assign cls_any_s = cls_a_s | cls_b_s;
  assign ma_s      = {1'b1, a0_r[MAN_W-1:0]};
  assign mb_s      = {1'b1, b0_r[MAN_W-1:0]};
  assign prod_s    = {{(MAN_W+1){1'b0}}, ma_s} * {{(MAN_W+1){1'b0}}, mb_s};

  // S1 stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      cls1_r  <= '0;
      ea1_r   <= '0;
      eb1_r   <= '0;
      prod1_r <= '0;
    end else if (en_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        sign1_r <= a0_r[W-1] ^ b0_r[W-1];
        cls1_r  <= cls_any_s;
        ea1_r   <= a0_r[W-2:MAN_W];
        eb1_r   <= b0_r[W-2:MAN_W];
        prod1_r <= prod_s;
      end
    end
  end

  // S2: normalise, exponent, round. The hidden bit is dropped from pn_s.
  logic              n_s, guard_s, sticky_s, rnd_up_s, ovf_s, unf_s;
  logic [PW-2:0]     pn_s;
  logic [MAN_W-1:0]  frac_s;
  logic [MAN_W:0]    frac_rnd_s;
  logic [EW-1:0]     e_sum_s, e_rnd_s;
  logic              sign2_r, inexact2_r, ovf2_r, unf2_r;
  cls_t              cls2_r;
  logic [EXP_W-1:0]  exp2_r;
  logic [MAN_W-1:0]  frac2_r;

  assign n_s        = prod1_r[PW-1];
  assign pn_s       = n_s ? prod1_r[PW-2:0] : {prod1_r[PW-3:0], 1'b0};
  assign frac_s     = pn_s[PW-2:MAN_W+1];
  assign guard_s    = pn_s[MAN_W];
  assign sticky_s   = |pn_s[MAN_W-1:0];
  assign rnd_up_s   = guard_s & (sticky_s | frac_s[0]);
  assign frac_rnd_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, rnd_up_s};
  assign e_sum_s    = {2'b00, ea1_r} + {2'b00, eb1_r} - BIAS + {{(EW-1){1'b0}}, n_s};
  assign e_rnd_s    = e_sum_s + {{(EW-1){1'b0}}, frac_rnd_s[MAN_W]};
  assign ovf_s      = $signed(e_rnd_s) >= $signed(EXP_MAX);
  assign unf_s      = $signed(e_rnd_s) <= $signed({EW{1'b0}});

  // S2 stage register; a rounding carry leaves the fraction at zero (mantissa 1.0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r       <= 1'b0;
      sign2_r    <= 1'b0;
      cls2_r     <= '0;
      exp2_r     <= '0;
      frac2_r    <= '0;
      inexact2_r <= 1'b0;
      ovf2_r     <= 1'b0;
      unf2_r     <= 1'b0;
    end else if (en_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sign2_r    <= sign1_r;
        cls2_r     <= cls1_r;
        exp2_r     <= e_rnd_s[EXP_W-1:0];
        frac2_r    <= frac_rnd_s[MAN_W-1:0];
        inexact2_r <= guard_s | sticky_s;
        ovf2_r     <= ovf_s;
        unf2_r     <= unf_s;
      end
    end
  end

  // S3: special-value override in priority order, then pack
  logic [W-1:0] res_s;
  logic [3:0]   flags_s;

  always_comb begin
    res_s   = {sign2_r, exp2_r, frac2_r};
    flags_s = {3'b000, inexact2_r};
    if (cls2_r.nan) begin
      res_s   = QNAN;
      flags_s = {cls2_r.snan, 3'b000};
    end else if (cls2_r.inf & cls2_r.zero) begin
      res_s   = QNAN;
      flags_s = 4'b1000;
    end else if (cls2_r.inf) begin
      res_s   = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_s = 4'b0000;
    end else if (cls2_r.zero) begin
      res_s   = {sign2_r, {(W-1){1'b0}}};
      flags_s = 4'b0000;
    end else if (ovf2_r) begin
      res_s   = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_s = 4'b0101;
    end else if (unf2_r) begin
      res_s   = {sign2_r, {(W-1){1'b0}}};
      flags_s = 4'b0011;
    end else begin
      res_s   = {sign2_r, exp2_r, frac2_r};
      flags_s = {3'b000, inexact2_r};
    end
  end

  // Output register; result and flags hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_res_r   <= '0;
      out_flags_r <= 4'b0000;
    end else if (en_s) begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        out_res_r   <= res_s;
        out_flags_r <= flags_s;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single-precision and double-precision instances,
// directed vectors with hand-computed results, backpressure and mid-flight reset.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  out_flags;
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] in_a64, in_b64, out_res64;
  logic [3:0]  out_flags64;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flags;
    int          cyc;
    bit          lat;
    int          id;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags)
  );

  fp_mul_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_a(in_a64), .in_b(in_b64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_res(out_res64), .out_flags(out_flags64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed single-precision vectors: a, b, product, {invalid,overflow,underflow,inexact}
  localparam int NV = 19;
  logic [31:0] va [NV] = '{32'h40400000, 32'h80000000, 32'h3F800001, 32'h3FC00000, 32'h3F800001,
                           32'h3F800003, 32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h7FC00000,
                           32'h7F000000, 32'h00800000, 32'h00000001, 32'h7F000000, 32'h7F000000,
                           32'h00800000, 32'h80800000, 32'hFF800000, 32'h00000001};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000,
                           32'h3FC00000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                           32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3FFFFFFF, 32'h40000000,
                           32'h3F800000, 32'h3F000000, 32'h80000000, 32'h7F800000};
  logic [31:0] vr [NV] = '{32'h40C00000, 32'h80000000, 32'h3F800002, 32'h40100000, 32'h3FC00002,
                           32'h3FC00004, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                           32'h7F800000, 32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'h7F800000,
                           32'h00800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000};
  logic [3:0]  vf [NV] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h8, 4'h8, 4'h0, 4'h0,
                           4'h5, 4'h3, 4'h0, 4'h0, 4'h5, 4'h0, 4'h3, 4'h8, 4'h8};

  // Backpressure stream: each operand times 2.0
  logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_r [6] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d]: actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [3:0] f, input bit lat, input bit push, input int id);
    bit acc = 1'b0;
    int tries = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) chk("accept_timeout", id, 64'd0, 64'd1);
    else if (push) q32.push_back('{res: {32'h0, r}, flags: f, cyc: cyc, lat: lat, id: id});
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                         input logic [3:0] f, input int id);
    bit acc = 1'b0;
    int tries = 0;
    in_valid64 = 1'b1;
    in_a64 = a;
    in_b64 = b;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = in_ready64;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid64 = 1'b0;
    if (!acc) chk("accept64_timeout", id, 64'd0, 64'd1);
    else q64.push_back('{res: r, flags: f, cyc: cyc, lat: 1'b1, id: id});
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() != 0 || q64.size() != 0) && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", 0, 64'(q32.size() + q64.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the single-precision instance
  initial begin
    exp_t e;
    bit prev_stall = 1'b0;
    logic [31:0] prev_res = 32'h0;
    logic [3:0]  prev_flags = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", 0, {63'd0, in_ready}, 64'd0);
          if (prev_stall) begin
            chk("hold_res", 0, {32'h0, out_res}, {32'h0, prev_res});
            chk("hold_flags", 0, {60'h0, out_flags}, {60'h0, prev_flags});
          end
        end
        if (out_valid && out_ready) begin
          if (q32.size() == 0) begin
            chk("unexpected_result", 0, {32'h0, out_res}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = q32.pop_front();
            chk("res", e.id, {32'h0, out_res}, e.res);
            chk("flags", e.id, {60'h0, out_flags}, {60'h0, e.flags});
            if (e.lat) chk("latency", e.id, 64'(cyc - e.cyc), 64'd3);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_res;
        prev_flags = out_flags;
      end
    end
  end

  // Monitor for the double-precision instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid64) begin
        if (q64.size() == 0) begin
          chk("unexpected_result64", 0, out_res64, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q64.pop_front();
          chk("res64", e.id, out_res64, e.res);
          chk("flags64", e.id, {60'h0, out_flags64}, {60'h0, e.flags});
          chk("latency64", e.id, 64'(cyc - e.cyc), 64'd3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_a64 = 64'h0; in_b64 = 64'h0; out_ready64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 0, {63'd0, out_valid}, 64'd0);
    chk("reset_out_res", 0, {32'h0, out_res}, 64'd0);
    chk("reset_out_flags", 0, {60'h0, out_flags}, 64'd0);
    chk("reset_out_valid64", 0, {63'd0, out_valid64}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 0, {63'd0, in_ready}, 64'd1);

    // Directed vectors, back-to-back with no stall
    for (int i = 0; i < NV; i++) issue(va[i], vb[i], vr[i], vf[i], 1'b1, 1'b1, i);
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 5 cycles starting 2 cycles in
    fork
      begin
        for (int i = 0; i < 6; i++) issue(bp_a[i], 32'h40000000, bp_r[i], 4'h0, 1'b0, 1'b1, 100 + i);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight; none of them may surface
    for (int i = 0; i < 3; i++) issue(bp_a[i], 32'h40000000, bp_r[i], 4'h0, 1'b0, 1'b0, 200 + i);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("inflight_out_valid", 0, {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 0, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h40400000, 32'h40000000, 32'h40C00000, 4'h0, 1'b1, 1'b1, 300);
    in_valid = 1'b0;
    drain();

    // Double precision
    issue64(64'h4008000000000000, 64'h4000000000000000, 64'h4018000000000000, 4'h0, 400);
    issue64(64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'h8, 401);
    drain();

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
